// File: rtl/wb_burst_master_if.sv
// Bundle between the burst master and its neighbours: command, write stream,
// read stream, status pulses and the Wishbone B3 bus.
interface wb_burst_master_if #(
  parameter int dw     = 32,
  parameter int APP_AW = 26,
  parameter int LEN_W  = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [APP_AW-1:0]   cmd_addr;
  logic [LEN_W-1:0]    cmd_len;

  logic                wr_valid;
  logic                wr_ready;
  logic [dw-1:0]       wr_data;
  logic [dw/8-1:0]     wr_sel;

  logic                rd_valid;
  logic [dw-1:0]       rd_data;
  logic                rd_last;

  logic                done;
  logic                err;

  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [APP_AW-1:0]   wb_addr_o;
  logic [dw-1:0]       wb_dat_o;
  logic [dw/8-1:0]     wb_sel_o;
  logic [2:0]          wb_cti_o;
  logic                wb_ack_i;
  logic [dw-1:0]       wb_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  wr_valid, wr_data, wr_sel,
    input  wb_ack_i, wb_dat_i,
    output cmd_ready, wr_ready,
    output rd_valid, rd_data, rd_last,
    output done, err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    output wr_valid, wr_data, wr_sel,
    output wb_ack_i, wb_dat_i,
    input  cmd_ready, wr_ready,
    input  rd_valid, rd_data, rd_last,
    input  done, err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one command becomes one classic or incrementing
// burst cycle, with a watchdog that aborts a cycle the slave stops acking.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WDATA | cycle open, strobe low, waiting for the next write beat
// XFER  | strobe high, waiting for ack or watchdog expiry
module wb_burst_master #(
  parameter int dw     = 32,
  parameter int APP_AW = 26,
  parameter int LEN_W  = 4,
  parameter int TO_CYC = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_burst_master_if.master  bus
);

  localparam int SEL_W = dw / 8;
  localparam int WD_W  = $clog2(TO_CYC + 1);

  localparam logic [APP_AW-1:0] STEP    = APP_AW'(SEL_W);
  localparam logic [WD_W-1:0]   WD_LOAD = WD_W'(TO_CYC - 1);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_wr_ready;
  logic                r_rd_valid;
  logic [dw-1:0]       r_rd_data;
  logic                r_rd_last;
  logic                r_done;
  logic                r_err;
  logic                r_cyc;
  logic                r_stb;
  logic                r_we;
  logic [APP_AW-1:0]   r_addr;
  logic [dw-1:0]       r_dat;
  logic [SEL_W-1:0]    r_sel;
  logic [2:0]          r_cti;
  logic [LEN_W-1:0]    r_beats_left;
  logic [WD_W-1:0]     r_wd;

  logic                w_cmd_take;
  logic                w_last;
  logic [LEN_W-1:0]    w_beats_next;

  assign w_cmd_take   = bus.cmd_valid && r_cmd_ready;
  assign w_last       = (r_beats_left == '0);
  assign w_beats_next = r_beats_left - LEN_W'(1);

  // Watchdog is a down-counter reloaded on every new strobe; it only runs in XFER.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b0;
      r_wr_ready   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_last    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_cti        <= '0;
      r_beats_left <= '0;
      r_wd         <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_take) begin
            r_cmd_ready  <= 1'b0;
            r_we         <= bus.cmd_we;
            r_addr       <= bus.cmd_addr;
            r_beats_left <= bus.cmd_len;
            r_cti        <= (bus.cmd_len == '0) ? CTI_CLASSIC : CTI_INCR;
            r_cyc        <= 1'b1;
            if (bus.cmd_we) begin
              r_wr_ready <= 1'b1;
              r_state    <= WDATA;
            end else begin
              r_stb   <= 1'b1;
              r_sel   <= '1;
              r_wd    <= WD_LOAD;
              r_state <= XFER;
            end
          end
        end

        WDATA: begin
          if (bus.wr_valid) begin
            r_dat      <= bus.wr_data;
            r_sel      <= bus.wr_sel;
            r_stb      <= 1'b1;
            r_wr_ready <= 1'b0;
            r_wd       <= WD_LOAD;
            r_state    <= XFER;
          end
        end

        XFER: begin
          if (bus.wb_ack_i) begin
            if (!r_we) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= bus.wb_dat_i;
              r_rd_last  <= w_last;
            end
            if (w_last) begin
              r_cyc       <= 1'b0;
              r_stb       <= 1'b0;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_addr       <= r_addr + STEP;
              r_beats_left <= w_beats_next;
              r_cti        <= (w_beats_next == '0) ? CTI_END : CTI_INCR;
              r_wd         <= WD_LOAD;
              if (r_we) begin
                r_stb      <= 1'b0;
                r_wr_ready <= 1'b1;
                r_state    <= WDATA;
              end
            end
          end else if (r_wd == '0) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_err       <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_wd <= r_wd - WD_W'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.wr_ready  = r_wr_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_last   = r_rd_last;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.wb_cyc_o  = r_cyc;
  assign bus.wb_stb_o  = r_stb;
  assign bus.wb_we_o   = r_we;
  assign bus.wb_addr_o = r_addr;
  assign bus.wb_dat_o  = r_dat;
  assign bus.wb_sel_o  = r_sel;
  assign bus.wb_cti_o  = r_cti;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: directed commands push expected beats,
// read returns and status events; a negedge monitor pops and compares them.
module tb_wb_burst_master;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam int LW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_burst_master_if #(.dw(DW), .APP_AW(AW), .LEN_W(LW)) bus ();

  wb_burst_master #(.dw(DW), .APP_AW(AW), .LEN_W(LW), .TO_CYC(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    logic          last;
    logic          first;
  } beat_t;

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
  } rd_t;

  beat_t exp_beats[$];
  rd_t   exp_rd[$];
  logic  exp_ev[$];  // 0 = done, 1 = err

  int n_run = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endfunction

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {6'b0, a};
  endfunction

  function automatic void exp_beat(input logic we, input logic [AW-1:0] a, input logic [2:0] cti,
                                   input logic [DW-1:0] d, input logic [3:0] s,
                                   input logic last, input logic first);
    beat_t b;
    rd_t   r;
    b.we = we; b.addr = a; b.cti = cti; b.dat = d; b.sel = s; b.last = last; b.first = first;
    exp_beats.push_back(b);
    if (!we) begin
      r.dat  = rd_pat(a);
      r.last = last;
      exp_rd.push_back(r);
    end
  endfunction

  // Slave model: ack after s_lat wait cycles per beat, optional never-ack and
  // spurious ack while the strobe is low.
  logic s_never = 1'b0;
  logic s_spur  = 1'b0;
  int   s_lat   = 0;
  int   s_wait  = 0;

  always @(posedge clk) begin
    #2;
    if (bus.wb_cyc_o && bus.wb_stb_o && !s_never) begin
      if (s_wait >= s_lat) begin
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = rd_pat(bus.wb_addr_o);
        s_wait = 0;
      end else begin
        bus.wb_ack_i = 1'b0;
        s_wait++;
      end
    end else begin
      bus.wb_ack_i = bus.wb_cyc_o && s_spur;
      bus.wb_dat_i = 32'hDEAD_BEEF;
      s_wait = 0;
    end
  end

  int   cyc_no = 0;
  int   n_beats = 0;
  int   n_done = 0;
  int   n_err = 0;
  int   last_beat_cyc = -10;
  int   stb_cnt = 0;
  int   gap_cnt = 0;
  logic prev_rd_ack = 1'b0;
  logic prev_last_ack = 1'b0;

  always @(negedge clk) begin : monitor
    beat_t b;
    rd_t   r;
    logic  ev;
    logic  acc;
    cyc_no++;

    if (bus.rd_valid || prev_rd_ack) chk("rd_timing", bus.rd_valid, prev_rd_ack);
    if (bus.rd_valid) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        r = exp_rd.pop_front();
        chk("rd_data", bus.rd_data, r.dat);
        chk("rd_last", bus.rd_last, r.last);
      end
    end

    if (bus.done || prev_last_ack) chk("done_timing", bus.done, prev_last_ack);
    if (bus.done || bus.err) begin
      if (exp_ev.size() == 0) chk("event_unexpected", {bus.done, bus.err}, 2'b00);
      else begin
        ev = exp_ev.pop_front();
        chk("event_kind", {bus.done, bus.err}, ev ? 2'b01 : 2'b10);
      end
      if (bus.err) chk("err_idle", {bus.wb_cyc_o, bus.wb_stb_o, bus.cmd_ready}, 3'b001);
    end

    acc = bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i;
    prev_rd_ack   = acc && !bus.wb_we_o;
    prev_last_ack = 1'b0;
    if (acc) begin
      if (exp_beats.size() == 0) chk("beat_unexpected", bus.wb_addr_o, 0);
      else begin
        b = exp_beats.pop_front();
        chk("beat_we", bus.wb_we_o, b.we);
        chk("beat_addr", bus.wb_addr_o, b.addr);
        chk("beat_cti", bus.wb_cti_o, b.cti);
        chk("beat_sel", bus.wb_sel_o, b.sel);
        if (b.we) chk("beat_wdata", bus.wb_dat_o, b.dat);
        if (s_lat == 0 && !b.we && !b.first) chk("beat_b2b", cyc_no, last_beat_cyc + 1);
        prev_last_ack = b.last;
      end
      last_beat_cyc = cyc_no;
      n_beats++;
    end
    if (bus.wb_cyc_o && bus.wb_stb_o) stb_cnt++;
    if (bus.wb_cyc_o && !bus.wb_stb_o) gap_cnt++;
    if (bus.done) n_done++;
    if (bus.err) n_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] len);
    int b = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    while (!bus.cmd_ready && b < 200) begin tick(); b++; end
    if (!bus.cmd_ready) chk("cmd_accept_timeout", 0, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] d, input logic [3:0] s, input int gap);
    int b = 0;
    repeat (gap) tick();
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_sel   = s;
    while (!bus.wr_ready && b < 200) begin tick(); b++; end
    if (!bus.wr_ready) chk("wr_accept_timeout", 0, 1);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int b = 0;
    while ((exp_beats.size() != 0 || exp_rd.size() != 0 || exp_ev.size() != 0) && b < 300) begin
      tick();
      b++;
    end
    if (exp_beats.size() != 0 || exp_rd.size() != 0 || exp_ev.size() != 0) begin
      chk({nm, "_drain_timeout"}, exp_beats.size() + exp_rd.size() + exp_ev.size(), 0);
      exp_beats.delete();
      exp_rd.delete();
      exp_ev.delete();
    end
    repeat (2) tick();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctrl"}, {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_cti_o, bus.wb_sel_o,
                        bus.wb_addr_o, bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last,
                        bus.done, bus.err}, 0);
    chk({nm, "_data"}, {bus.wb_dat_o, bus.rd_data}, 0);
  endtask

  initial begin : stim
    int b;
    int base;
    int done0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_sel    = '0;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("cmd_ready_after_reset", bus.cmd_ready, 1);

    // 1: single read, slave waits 2 cycles
    s_lat = 2;
    exp_beat(0, 26'h0000100, 3'b000, 0, 4'hF, 1, 1);
    exp_ev.push_back(1'b0);
    send_cmd(0, 26'h0000100, 0);
    drain("single_read");

    // 2: 4-beat read wrapping the address space, back-to-back acks
    s_lat = 0;
    exp_beat(0, 26'h3FFFFF8, 3'b010, 0, 4'hF, 0, 1);
    exp_beat(0, 26'h3FFFFFC, 3'b010, 0, 4'hF, 0, 0);
    exp_beat(0, 26'h0000000, 3'b010, 0, 4'hF, 0, 0);
    exp_beat(0, 26'h0000004, 3'b111, 0, 4'hF, 1, 0);
    exp_ev.push_back(1'b0);
    send_cmd(0, 26'h3FFFFF8, 3);
    drain("wrap_read");

    // 3: 3-beat write with a 5-cycle data gap and spurious acks while stb is low
    s_spur = 1'b1;
    gap_cnt = 0;
    base = n_err;
    exp_beat(1, 26'h0002000, 3'b010, 32'h1111_AAAA, 4'hF, 0, 1);
    exp_beat(1, 26'h0002004, 3'b010, 32'h2222_BBBB, 4'h3, 0, 0);
    exp_beat(1, 26'h0002008, 3'b111, 32'h3333_CCCC, 4'hC, 1, 0);
    exp_ev.push_back(1'b0);
    send_cmd(1, 26'h0002000, 2);
    feed(32'h1111_AAAA, 4'hF, 0);
    feed(32'h2222_BBBB, 4'h3, 5);
    feed(32'h3333_CCCC, 4'hC, 0);
    drain("gap_write");
    s_spur = 1'b0;
    chk("wr_gap_stb_low", gap_cnt >= 5, 1);
    chk("wr_gap_no_err", n_err, base);

    // 4: slave never acks; watchdog aborts after TO strobe cycles
    s_never = 1'b1;
    stb_cnt = 0;
    base = n_done;
    exp_ev.push_back(1'b1);
    send_cmd(0, 26'h0000080, 0);
    drain("timeout");
    s_never = 1'b0;
    chk("timeout_stb_cycles", stb_cnt, TO);
    chk("timeout_no_done", n_done, base);

    // 5: reset during beat 2 of a 4-beat read
    s_lat = 2;
    base = n_beats;
    exp_beat(0, 26'h0001000, 3'b010, 0, 4'hF, 0, 1);
    exp_beat(0, 26'h0001004, 3'b010, 0, 4'hF, 0, 0);
    send_cmd(0, 26'h0001000, 3);
    b = 0;
    while (n_beats < base + 2 && b < 100) begin tick(); b++; end
    if (n_beats < base + 2) chk("reset_mid_wait_timeout", n_beats - base, 2);
    rst_n = 1'b0;
    tick();
    chk_all_zero("reset_mid");
    rst_n = 1'b1;
    tick();
    chk("cmd_ready_after_mid_reset", bus.cmd_ready, 1);
    drain("reset_mid");
    s_lat = 0;
    exp_beat(0, 26'h0000040, 3'b000, 0, 4'hF, 1, 1);
    exp_ev.push_back(1'b0);
    send_cmd(0, 26'h0000040, 0);
    drain("after_reset_read");

    // 6: back-to-back commands with cmd_valid held high
    exp_beat(0, 26'h0000200, 3'b000, 0, 4'hF, 1, 1);
    exp_ev.push_back(1'b0);
    exp_beat(0, 26'h0000300, 3'b010, 0, 4'hF, 0, 1);
    exp_beat(0, 26'h0000304, 3'b111, 0, 4'hF, 1, 0);
    exp_ev.push_back(1'b0);
    done0 = n_done;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 26'h0000200;
    bus.cmd_len   = 0;
    b = 0;
    while (!bus.cmd_ready && b < 50) begin tick(); b++; end
    tick();
    bus.cmd_addr = 26'h0000300;
    bus.cmd_len  = 1;
    chk("b2b_busy_not_ready", bus.cmd_ready, 0);
    b = 0;
    while (!bus.cmd_ready && b < 50) begin tick(); b++; end
    chk("b2b_done_with_ready", bus.done, 1);
    chk("b2b_idle_cyc_low", bus.wb_cyc_o, 0);
    chk("b2b_first_not_done_yet", n_done, done0);
    tick();
    chk("b2b_second_taken", {bus.cmd_ready, bus.wb_cyc_o, bus.wb_addr_o}, {1'b0, 1'b1, 26'h0000300});
    bus.cmd_valid = 1'b0;
    drain("b2b");
    chk("b2b_done_count", n_done, done0 + 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
